// File: rtl/mem_burst_master.sv
// Burst request master for memory_handshake: one command becomes a run of single-word
// valid/ready memory transactions, with a wrapping address and streamed write/read data.
module mem_burst_master #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [WIDTH-1:0]      wr_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  output logic                  mem_wr_rd_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {IDLE, FETCH, REQ, WAITRD, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   beats_q, beats_d;
  logic                  dir_q, dir_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] addr_inc;

  // Address wraps at the last memory location so long bursts revisit locations.
  assign addr_inc = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    dir_d      = dir_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rd_valid_d = rd_valid_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          beats_d = cmd_len_i;
          dir_d   = cmd_wr_rd_i;
          if (cmd_len_i == '0)
            state_d = DONE;
          else if (cmd_wr_rd_i)
            state_d = FETCH;
          else
            state_d = REQ;
        end
      end
      FETCH: begin
        if (wr_valid_i) begin
          wdata_d = wr_data_i;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ready_i) begin
          beats_d = beats_q - 1'b1;
          addr_d  = addr_inc;
          if (dir_q) begin
            state_d = (beats_q == (ADDR_WIDTH+1)'(1)) ? DONE : FETCH;
          end else begin
            rdata_d    = mem_rdata_i;
            rd_valid_d = 1'b1;
            state_d    = WAITRD;
          end
        end
      end
      WAITRD: begin
        if (rd_ready_i) begin
          rd_valid_d = 1'b0;
          state_d    = (beats_q == '0) ? DONE : REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      beats_q    <= '0;
      dir_q      <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      dir_q      <= dir_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign wr_ready_o  = (state_q == FETCH);
  assign mem_valid_o = (state_q == REQ);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wr_rd_o = dir_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rdata_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Testbench for mem_burst_master: a table of bursts against a behavioural memory with
// configurable stall, plus hand-written backpressure and reset-mid-burst sequences.
module tb_mem_burst_master;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_wr_rd;
  logic [AW-1:0]    cmd_addr;
  logic [AW:0]      cmd_len;
  logic             wr_valid, wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid, rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;
  logic             mem_wr_rd, mem_valid, mem_ready;
  logic             busy, done;

  mem_burst_master #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_wr_rd_i(cmd_wr_rd),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wr_rd_o(mem_wr_rd),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Behavioural memory: ready comes after stall_cfg waiting cycles of valid.
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  int               stall_cfg = 0;
  int               wait_cnt;
  assign mem_ready = mem_valid && (wait_cnt >= stall_cfg);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (mem_valid && mem_ready) wait_cnt <= 0;
    else if (mem_valid) wait_cnt <= wait_cnt + 1;
  end

  // Transaction logs grow monotonically; each test remembers its base indices.
  logic [AW-1:0]    log_addr  [0:255];
  logic [WIDTH-1:0] log_wdata [0:255];
  logic             log_wr    [0:255];
  int               log_waits [0:255];
  logic [WIDTH-1:0] rd_log    [0:255];
  logic [WIDTH-1:0] wr_words  [0:255];
  int mem_cnt = 0, rd_cnt = 0, wr_idx = 0, done_cnt = 0, hold_err = 0;

  assign wr_data = wr_words[wr_idx];

  always @(posedge clk) begin
    if (mem_valid && mem_ready) begin
      log_addr[mem_cnt]  <= mem_addr;
      log_wdata[mem_cnt] <= mem_wdata;
      log_wr[mem_cnt]    <= mem_wr_rd;
      log_waits[mem_cnt] <= wait_cnt;
      mem_cnt            <= mem_cnt + 1;
      if (mem_wr_rd) mem[mem_addr] <= mem_wdata;
    end
    if (rd_valid && rd_ready) begin
      rd_log[rd_cnt] <= rd_data;
      rd_cnt         <= rd_cnt + 1;
    end
    if (wr_valid && wr_ready) wr_idx <= wr_idx + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // Memory request qualifiers must not move while a stalled request is pending.
  logic             prev_stall = 1'b0;
  logic [AW-1:0]    prev_addr;
  logic [WIDTH-1:0] prev_wdata;
  logic             prev_wr;
  always @(negedge clk) begin
    if (prev_stall && mem_valid &&
        (mem_addr !== prev_addr || mem_wdata !== prev_wdata || mem_wr_rd !== prev_wr))
      hold_err <= hold_err + 1;
    prev_stall <= mem_valid && !mem_ready && !rst;
    prev_addr  <= mem_addr;
    prev_wdata <= mem_wdata;
    prev_wr    <= mem_wr_rd;
  end

  typedef struct {
    logic wr;
    int   addr;
    int   len;
    int   stall;
    int   exp_done;
  } vec_t;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [WIDTH-1:0] shadow [0:DEPTH-1];
  int               base_mem, base_rd, base_wr, base_done;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic mark_bases();
    base_mem  = mem_cnt;
    base_rd   = rd_cnt;
    base_wr   = wr_idx;
    base_done = done_cnt;
  endtask

  task automatic issue_cmd(input logic wr, input int addr, input int len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_wr_rd = wr;
    cmd_addr  = AW'(addr);
    cmd_len   = (AW+1)'(len);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Runs one burst; done_at counts cycles after the acceptance edge (0 = next cycle).
  task automatic applyStimulus(input vec_t v, output int done_at, output int busy_bad);
    stall_cfg = v.stall;
    mark_bases();
    for (int i = 0; i < v.len; i++) wr_words[wr_idx + i] = WIDTH'($urandom_range(0, 65535));
    issue_cmd(v.wr, v.addr, v.len);
    done_at  = -1;
    busy_bad = 0;
    for (int k = 0; k < 400 && done_at < 0; k++) begin
      if (!busy) busy_bad++;
      if (done) done_at = k;
      else @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic checkOutput(input vec_t v, input int done_at, input int busy_bad);
    check("done_latency", 32'(done_at), 32'(v.exp_done));
    check("busy_during_burst", 32'(busy_bad), 32'd0);
    check("done_pulses", 32'(done_cnt - base_done), 32'd1);
    check("idle_after_done", {30'd0, busy, cmd_ready}, 32'd1);
    check("mem_beats", 32'(mem_cnt - base_mem), 32'(v.len));
    check("wr_fetches", 32'(wr_idx - base_wr), v.wr ? 32'(v.len) : 32'd0);
    check("rd_words", 32'(rd_cnt - base_rd), v.wr ? 32'd0 : 32'(v.len));
    check("stall_hold", 32'(hold_err), 32'd0);
    for (int i = 0; i < v.len; i++) begin
      int a;
      a = (v.addr + i) % DEPTH;
      check("beat_addr", 32'(log_addr[base_mem + i]), 32'(a));
      check("beat_dir", 32'(log_wr[base_mem + i]), 32'(v.wr));
      check("beat_waits", 32'(log_waits[base_mem + i]), 32'(v.stall));
      if (v.wr) begin
        check("beat_wdata", 32'(log_wdata[base_mem + i]), 32'(wr_words[base_wr + i]));
        shadow[a] = wr_words[base_wr + i];
      end else begin
        check("rd_data", 32'(rd_log[base_rd + i]), 32'(shadow[a]));
      end
    end
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;
    int   done_at, busy_bad, k;

    // {wr, addr, len, stall, expected done cycle after acceptance}
    vecs[0] = '{1'b1, 0,  16, 0, 32};
    vecs[1] = '{1'b0, 0,  16, 0, 32};
    vecs[2] = '{1'b1, 14, 4,  3, 20};
    vecs[3] = '{1'b0, 14, 4,  1, 12};
    vecs[4] = '{1'b1, 0,  0,  0, 0};
    vecs[5] = '{1'b0, 5,  0,  0, 0};
    vecs[6] = '{1'b1, 3,  20, 0, 40};
    vecs[7] = '{1'b0, 3,  20, 0, 40};

    rst = 1'b1; cmd_valid = 1'b0; cmd_wr_rd = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b1; rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_outputs", {25'd0, busy, done, mem_valid, wr_ready, rd_valid, mem_wr_rd, 1'b0}, 32'd0);
    check("rst_data", {rd_data, mem_wdata}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], done_at, busy_bad);
      checkOutput(vecs[i], done_at, busy_bad);
    end

    // Read backpressure: first word held while the consumer stalls.
    $display("[TB] backpressure sequence");
    stall_cfg = 0;
    rd_ready  = 1'b0;
    mark_bases();
    issue_cmd(1'b0, 0, 3);
    for (k = 0; k < 20 && !rd_valid; k++) @(negedge clk);
    check("bp_first_valid", 32'(rd_valid), 32'd1);
    for (int j = 0; j < 5; j++) begin
      check("bp_hold_valid", 32'(rd_valid), 32'd1);
      check("bp_hold_data", 32'(rd_data), 32'(shadow[0]));
      check("bp_no_request", 32'(mem_valid), 32'd0);
      @(negedge clk);
    end
    rd_ready = 1'b1;
    for (k = 0; k < 50 && !done; k++) @(negedge clk);
    check("bp_done", 32'(done), 32'd1);
    @(negedge clk);
    check("bp_mem_beats", 32'(mem_cnt - base_mem), 32'd3);
    check("bp_rd_words", 32'(rd_cnt - base_rd), 32'd3);
    for (int i = 0; i < 3; i++) check("bp_rd_data", 32'(rd_log[base_rd + i]), 32'(shadow[i]));

    // Reset during the third beat's memory request.
    $display("[TB] reset mid-burst sequence");
    mark_bases();
    for (int i = 0; i < 8; i++) wr_words[wr_idx + i] = WIDTH'($urandom_range(1, 65535));
    issue_cmd(1'b1, 8, 8);
    for (k = 0; k < 50 && !((mem_cnt - base_mem == 2) && mem_valid); k++) @(negedge clk);
    check("rm_third_req", 32'(mem_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rm_mem_valid", 32'(mem_valid), 32'd0);
    check("rm_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rm_outputs", {26'd0, busy, done, wr_ready, rd_valid, mem_wr_rd, 1'b0}, 32'd0);
    check("rm_addr_data", {12'd0, mem_addr, mem_wdata}, 32'd0);
    shadow[8] = wr_words[base_wr];
    shadow[9] = wr_words[base_wr + 1];
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rm_ready_after", 32'(cmd_ready), 32'd1);
    check("rm_no_done", 32'(done_cnt - base_done), 32'd0);
    check("rm_two_beats", 32'(mem_cnt - base_mem), 32'd2);
    v = '{1'b0, 8, 3, 0, 6};
    applyStimulus(v, done_at, busy_bad);
    checkOutput(v, done_at, busy_bad);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
